// File: rtl/pulse_chain_sequencer_pkg.sv
// Shared constants, FSM state encoding and per-channel config record for the
// optical sync pulse chain sequencer.
package pulse_chain_sequencer_pkg;

  localparam int N_CH   = 8;
  localparam int CNT_W  = 17;
  localparam int MULT_W = 5;
  localparam int CH_W   = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_PULSE,
    S_DELAY,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [CNT_W-1:0]  drt;
    logic [CNT_W-1:0]  del;
    logic [MULT_W-1:0] mult_pl;
    logic [MULT_W-1:0] mult_dl;
  } ch_cfg_t;

endpackage

// File: rtl/pulse_chain_sequencer_scaled_down_counter.sv
// Prescaled down-counter: a phase of count ticks, each tick mult+1 cycles long.
// done is high during the final cycle of the phase while en is asserted.
module scaled_down_counter
  import pulse_chain_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              en,
  input  logic [CNT_W-1:0]  count,
  input  logic [MULT_W-1:0] mult,
  output logic              done
);

  logic [CNT_W-1:0]  cnt;
  logic [MULT_W-1:0] pre;

  // mult is held stable by the caller for the whole phase, so it is reused on reload.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      pre <= '0;
    end else if (load) begin
      cnt <= count;
      pre <= mult;
    end else if (en) begin
      if (pre == '0) begin
        pre <= mult;
        if (cnt != '0) cnt <= cnt - 1'b1;
      end else begin
        pre <= pre - 1'b1;
      end
    end
  end

  assign done = en && (pre == '0) && (cnt == CNT_W'(1));

endmodule

// File: rtl/pulse_chain_sequencer.sv
// Sequences channels 0..N_CH-1: fetch config, pulse ch_out[index], then delay.
// All outputs are registered from the next-state decode.
module pulse_chain_sequencer
  import pulse_chain_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              cfg_rd,
  output logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_drt,
  input  logic [CNT_W-1:0]  cfg_del,
  input  logic [MULT_W-1:0] cfg_mult_pl,
  input  logic [MULT_W-1:0] cfg_mult_dl,
  output logic [N_CH-1:0]   ch_out,
  output logic              busy,
  output logic              cfg_lock,
  output logic              end_flg
);

  state_t            state, state_nx;
  logic [CH_W-1:0]   idx, idx_nx;
  ch_cfg_t           cfg_q, cfg_nx;
  logic              advance;
  logic              cnt_load, cnt_en, cnt_done;
  logic [CNT_W-1:0]  cnt_val;
  logic [MULT_W-1:0] cnt_mult;

  assign cnt_en = (state == S_PULSE) || (state == S_DELAY);

  scaled_down_counter u_cnt (
    .clk   (clk),
    .rst   (rst),
    .load  (cnt_load),
    .en    (cnt_en),
    .count (cnt_val),
    .mult  (cnt_mult),
    .done  (cnt_done)
  );

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    cfg_nx   = cfg_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_mult = (state == S_DELAY) ? cfg_q.mult_dl : cfg_q.mult_pl;
    advance  = 1'b0;
    case (state)
      S_IDLE: begin
        idx_nx = '0;
        if (start) state_nx = S_FETCH;
      end
      S_FETCH: state_nx = S_LOAD;
      S_LOAD: begin
        // Read data is on the cfg_* pins this cycle, so branch on it directly.
        cfg_nx = '{drt: cfg_drt, del: cfg_del, mult_pl: cfg_mult_pl, mult_dl: cfg_mult_dl};
        if (cfg_drt != '0) begin
          state_nx = S_PULSE;
          cnt_load = 1'b1;
          cnt_val  = cfg_drt;
          cnt_mult = cfg_mult_pl;
        end else if (cfg_del != '0) begin
          state_nx = S_DELAY;
          cnt_load = 1'b1;
          cnt_val  = cfg_del;
          cnt_mult = cfg_mult_dl;
        end else begin
          advance = 1'b1;
        end
      end
      S_PULSE: begin
        if (cnt_done || (cfg_q.drt == '0)) begin
          if (cfg_q.del != '0) begin
            state_nx = S_DELAY;
            cnt_load = 1'b1;
            cnt_val  = cfg_q.del;
            cnt_mult = cfg_q.mult_dl;
          end else begin
            advance = 1'b1;
          end
        end
      end
      S_DELAY: if (cnt_done) advance = 1'b1;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase

    if (advance) begin
      if (idx == CH_W'(N_CH - 1)) begin
        state_nx = S_DONE;
      end else begin
        state_nx = S_FETCH;
        idx_nx   = idx + 1'b1;
      end
    end

    if (abort && (state != S_IDLE)) begin
      state_nx = S_IDLE;
      idx_nx   = '0;
      cnt_load = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      idx     <= '0;
      cfg_q   <= '0;
      ch_out  <= '0;
      cfg_rd  <= 1'b0;
      cfg_ch  <= '0;
      busy    <= 1'b0;
      end_flg <= 1'b0;
    end else begin
      state   <= state_nx;
      idx     <= idx_nx;
      cfg_q   <= cfg_nx;
      ch_out  <= (state_nx == S_PULSE) ? (N_CH'(1) << idx_nx) : '0;
      cfg_rd  <= (state_nx == S_FETCH);
      cfg_ch  <= idx_nx;
      busy    <= (state_nx != S_IDLE);
      end_flg <= (state_nx == S_DONE);
    end
  end

  assign cfg_lock = busy;

endmodule

// File: tb/tb_pulse_chain_sequencer.sv
// Bench for pulse_chain_sequencer: a per-cycle expected-output queue built from
// the channel timing rules, plus directed scenarios with literal timing checks.
module tb_pulse_chain_sequencer;
  import pulse_chain_sequencer_pkg::*;

  logic              clk = 1'b0;
  logic              rst, start, abort;
  logic              cfg_rd;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_drt = '0, cfg_del = '0;
  logic [MULT_W-1:0] cfg_mult_pl = '0, cfg_mult_dl = '0;
  logic [N_CH-1:0]   ch_out;
  logic              busy, cfg_lock, end_flg;

  pulse_chain_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_rd(cfg_rd), .cfg_ch(cfg_ch),
    .cfg_drt(cfg_drt), .cfg_del(cfg_del),
    .cfg_mult_pl(cfg_mult_pl), .cfg_mult_dl(cfg_mult_dl),
    .ch_out(ch_out), .busy(busy), .cfg_lock(cfg_lock), .end_flg(end_flg)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // config RAM with one-cycle read latency
  logic [CNT_W-1:0]  ram_drt [N_CH];
  logic [CNT_W-1:0]  ram_del [N_CH];
  logic [MULT_W-1:0] ram_mpl [N_CH];
  logic [MULT_W-1:0] ram_mdl [N_CH];

  always @(posedge clk) begin
    if (cfg_rd === 1'b1) begin
      cfg_drt     <= ram_drt[cfg_ch];
      cfg_del     <= ram_del[cfg_ch];
      cfg_mult_pl <= ram_mpl[cfg_ch];
      cfg_mult_dl <= ram_mdl[cfg_ch];
    end
  end

  // expected word: {end_flg, busy, cfg_rd, cfg_ch, ch_out}
  localparam int W = 3 + CH_W + N_CH;
  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  function automatic logic [W-1:0] mk(input logic e, input logic b, input logic r,
                                      input logic [CH_W-1:0] c, input logic [N_CH-1:0] o);
    return {e, b, r, c, o};
  endfunction

  // Whole run as a cycle list: the current (idle) cycle, then per channel
  // FETCH, LOAD, drt*(mult_pl+1) pulse cycles, del*(mult_dl+1) gap cycles, then DONE.
  function automatic void push_run();
    exp_q.push_back('0);
    for (int i = 0; i < N_CH; i++) begin
      logic [N_CH-1:0] oh;
      int p, d;
      oh = '0;
      oh[i] = 1'b1;
      p = int'(ram_drt[i]) * (int'(ram_mpl[i]) + 1);
      d = int'(ram_del[i]) * (int'(ram_mdl[i]) + 1);
      exp_q.push_back(mk(1'b0, 1'b1, 1'b1, CH_W'(i), '0));
      exp_q.push_back(mk(1'b0, 1'b1, 1'b0, '0, '0));
      for (int k = 0; k < p; k++) exp_q.push_back(mk(1'b0, 1'b1, 1'b0, '0, oh));
      for (int k = 0; k < d; k++) exp_q.push_back(mk(1'b0, 1'b1, 1'b0, '0, '0));
    end
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, '0, '0));
  endfunction

  // monitor state for literal timing checks
  int hi_cnt [N_CH];
  int first_hi [N_CH];
  int fetch_cyc [N_CH];
  int end_cnt, end_cyc;

  // scoreboard compare, every cycle away from the active edge
  always @(negedge clk) begin
    logic [W-1:0] e, a;
    if (chk_en) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = '0;
      a = mk(end_flg, busy, cfg_rd, (cfg_rd === 1'b1) ? cfg_ch : '0, ch_out);
      n_vec++;
      if (a !== e) begin
        n_err++;
        $display("FAIL cycle_outputs @%0d: got {end,busy,rd,ch,out}=%h expected %h", cyc, a, e);
      end
      n_vec++;
      if (cfg_lock !== busy) begin
        n_err++;
        $display("FAIL cfg_lock @%0d: got %b expected %b", cyc, cfg_lock, busy);
      end
      for (int i = 0; i < N_CH; i++)
        if (ch_out[i] === 1'b1) begin
          if (hi_cnt[i] == 0) first_hi[i] = cyc;
          hi_cnt[i]++;
        end
      if (cfg_rd === 1'b1) fetch_cyc[cfg_ch] = cyc;
      if (end_flg === 1'b1) begin
        end_cnt++;
        end_cyc = cyc;
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clr_mon();
    for (int i = 0; i < N_CH; i++) begin
      hi_cnt[i] = 0;
      first_hi[i] = -1;
      fetch_cyc[i] = -1;
    end
    end_cnt = 0;
    end_cyc = -1;
  endtask

  task automatic clr_cfg();
    for (int i = 0; i < N_CH; i++) begin
      ram_drt[i] = '0; ram_del[i] = '0; ram_mpl[i] = '0; ram_mdl[i] = '0;
    end
  endtask

  task automatic set_cfg(input int ch, input int drt, input int mpl, input int del, input int mdl);
    ram_drt[ch] = CNT_W'(drt);
    ram_mpl[ch] = MULT_W'(mpl);
    ram_del[ch] = CNT_W'(del);
    ram_mdl[ch] = MULT_W'(mdl);
  endtask

  // Drive start for one cycle; a start while a run is pending is dropped.
  task automatic do_start(output int t0);
    t0 = cyc;
    start = 1'b1;
    if (exp_q.size() == 0) push_run();
    tick();
    start = 1'b0;
  endtask

  task automatic cut_run();
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q[0];
      exp_q.delete();
      exp_q.push_back(e);
    end
  endtask

  task automatic do_abort();
    abort = 1'b1;
    cut_run();
    tick();
    abort = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    cut_run();
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL run_timeout: %0d cycles still expected after %0d", exp_q.size(), budget);
      exp_q.delete();
    end
    tick();
  endtask

  initial begin
    int t0;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    clr_cfg();
    clr_mon();
    tick(); tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    check("reset_ch_out", int'(ch_out), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_cfg_rd", int'(cfg_rd), 0);
    check("reset_cfg_ch", int'(cfg_ch), 0);
    check("reset_end_flg", int'(end_flg), 0);
    tick();

    // basic: ch0 4-cycle pulse, 4-cycle delay, rest empty
    clr_cfg();
    set_cfg(0, 4, 0, 2, 1);
    clr_mon();
    do_start(t0);
    wait_idle(200);
    check("basic_first_hi", first_hi[0] - t0, 3);
    check("basic_hi_cnt", hi_cnt[0], 4);
    check("basic_ch1_fetch", fetch_cyc[1] - t0, 11);
    check("basic_ch7_fetch", fetch_cyc[7] - t0, 23);
    check("basic_end_cyc", end_cyc - t0, 25);
    check("basic_end_cnt", end_cnt, 1);

    // prescale max: one tick of 32 cycles
    clr_cfg();
    set_cfg(0, 1, 31, 0, 0);
    clr_mon();
    do_start(t0);
    wait_idle(200);
    check("pmax_hi_cnt", hi_cnt[0], 32);
    check("pmax_end_cyc", end_cyc - t0, 49);

    // retrigger while busy is dropped
    clr_cfg();
    set_cfg(0, 4, 0, 2, 1);
    clr_mon();
    do_start(t0);
    repeat (5) tick();
    do_start(t0);
    t0 = t0 - 6;
    wait_idle(200);
    check("retrig_end_cnt", end_cnt, 1);
    check("retrig_end_cyc", end_cyc - t0, 25);
    check("retrig_hi_cnt", hi_cnt[0], 4);

    // abort on the 3rd high cycle of a 10-cycle pulse
    clr_cfg();
    set_cfg(0, 10, 0, 0, 0);
    clr_mon();
    do_start(t0);
    repeat (4) tick();
    do_abort();
    check("abort_ch_out", int'(ch_out), 0);
    check("abort_busy", int'(busy), 0);
    repeat (4) tick();
    check("abort_hi_cnt", hi_cnt[0], 3);
    check("abort_end_cnt", end_cnt, 0);
    clr_mon();
    do_start(t0);
    wait_idle(200);
    check("post_abort_hi_cnt", hi_cnt[0], 10);
    check("post_abort_end_cyc", end_cyc - t0, 27);

    // zero pulse with delay on ch2; abort in IDLE first (no effect)
    clr_cfg();
    set_cfg(2, 0, 0, 5, 0);
    do_abort();
    clr_mon();
    do_start(t0);
    wait_idle(200);
    check("zp_hi_cnt2", hi_cnt[2], 0);
    check("zp_ch2_fetch", fetch_cyc[2] - t0, 5);
    check("zp_ch3_fetch", fetch_cyc[3] - t0, 12);
    check("zp_end_cyc", end_cyc - t0, 22);

    // several channels with mixed prescales
    clr_cfg();
    set_cfg(1, 2, 1, 1, 3);
    set_cfg(5, 3, 2, 0, 0);
    set_cfg(7, 1, 0, 1, 0);
    clr_mon();
    do_start(t0);
    wait_idle(300);
    check("mix_first_hi1", first_hi[1] - t0, 5);
    check("mix_hi_cnt1", hi_cnt[1], 4);
    check("mix_first_hi5", first_hi[5] - t0, 21);
    check("mix_hi_cnt5", hi_cnt[5], 9);
    check("mix_first_hi7", first_hi[7] - t0, 34);
    check("mix_end_cyc", end_cyc - t0, 36);

    // reset held 3 cycles mid-run
    clr_cfg();
    set_cfg(0, 4, 0, 2, 1);
    clr_mon();
    do_start(t0);
    repeat (5) tick();
    do_reset(3);
    check("rst_ch_out", int'(ch_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_state", int'(dut.state), int'(S_IDLE));
    repeat (5) tick();
    check("rst_end_cnt", end_cnt, 0);
    clr_mon();
    do_start(t0);
    wait_idle(200);
    check("post_rst_end_cyc", end_cyc - t0, 25);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
